// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch : instruction-fetch stage of the single-issue MIPS core.
//
// Holds the program counter, requests one instruction word at a time from
// instruction memory over a req/ready handshake, latches the returned word for
// the decoder and computes the next PC from the decoder's branch/jump controls.
//
// Ports
//   clk, rst_n          core clock (rising edge), asynchronous active-low reset
//   imem_req/addr       fetch request and word-aligned address (= pc)
//   imem_ready/rdata    memory response, sampled only while fetching
//   instr, op_c, funct  latched instruction and its decoder fields
//   instr_valid         instr is in execute this cycle
//   pc, pc_plus4        current instruction address and its link value
//   stall               hold the current instruction in execute
//   beq,bne,j_c,jr_c    decoder controls; zero = ALU equality flag
//   jr_target           rs value for jr
//   misalign_err        sticky: a misaligned jr target was taken
//   fetch_err           sticky: fetch watchdog expired
//
// Build option
//   FETCH_TIMEOUT_EN    when defined, a watchdog counts cycles spent waiting in
//                       FETCH; after TIMEOUT_CYCLES cycles without imem_ready it
//                       sets fetch_err, drops imem_req for one cycle and then
//                       re-requests the same pc. Otherwise FETCH waits forever
//                       and fetch_err is tied low.
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op_c,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        beq,
  input  logic        bne,
  input  logic        j_c,
  input  logic        jr_c,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic        misalign_err,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] next_pc;
  logic        br_taken;
  logic [31:0] br_offset;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;
  logic          ferr_q, ferr_d;
`endif

  assign pc_plus4_w = pc_q + 32'd4;

  // Branch offset: sign-extended word offset relative to pc+4.
  assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign br_taken  = (beq & zero) | (bne & ~zero);

  always_comb begin
    next_pc = pc_plus4_w;
    if (jr_c) begin
      next_pc = {jr_target[31:2], 2'b00};
    end else if (j_c) begin
      next_pc = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    end else if (br_taken) begin
      next_pc = pc_plus4_w + br_offset;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    drop_d     = 1'b0;
    ferr_d     = ferr_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      FETCH: begin
`ifdef FETCH_TIMEOUT_EN
        // The dropped-request cycle ignores ready; counting restarts after it.
        if (drop_q) begin
          cnt_d = '0;
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          ferr_d = 1'b1;
          drop_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
`endif
      end
      EXEC: begin
        // While stalled everything is held and the controls are ignored.
        if (!stall) begin
          pc_d    = next_pc;
          state_d = FETCH;
          if (jr_c && (jr_target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      drop_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      ferr_q <= ferr_d;
    end
  end

  assign imem_req  = (state_q == FETCH) && !drop_q;
  assign fetch_err = ferr_q;
`else
  assign imem_req  = (state_q == FETCH);
  assign fetch_err = 1'b0;
`endif

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_plus4_w;
  assign instr        = instr_q;
  assign op_c         = instr_q[31:26];
  assign funct        = instr_q[5:0];
  assign instr_valid  = (state_q == EXEC);
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [5:0]  op_c;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0;
  logic        beq = 1'b0, bne = 1'b0, j_c = 1'b0, jr_c = 1'b0, zero = 1'b0;
  logic [31:0] jr_target = '0;
  logic        misalign_err;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  // Instruction-level reference state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_mis;

  pc_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .op_c(op_c), .funct(funct), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
    .beq(beq), .bne(bne), .j_c(j_c), .jr_c(jr_c), .zero(zero),
    .jr_target(jr_target), .misalign_err(misalign_err), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next PC straight from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic b_eq, input logic b_ne, input logic jj,
                                           input logic jr, input logic z, input logic [31:0] tgt);
    logic [31:0] link;
    logic signed [31:0] imm;
    link = cur + 32'd4;
    imm  = 32'(signed'(ins[15:0]));
    if (jr) return tgt & 32'hFFFF_FFFC;
    if (jj) return (link & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if ((b_eq && z) || (b_ne && !z)) return link + 32'(imm * 4);
    return link;
  endfunction

  // Serve one fetch: wait for the request, hold ready low for dly cycles, return word.
  task automatic do_fetch(input int dly, input logic [31:0] word);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) chk("req_wait_expired", 32'd0, 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_nvalid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < dly; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("req_hold", {31'd0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, m_pc);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    m_instr = word;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_nreq", {31'd0, imem_req}, 32'd0);
    chk("instr", instr, m_instr);
    chk("op_c", {26'd0, op_c}, {26'd0, m_instr[31:26]});
    chk("funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
  endtask

  // Execute the latched instruction: stall st cycles (junk controls), then apply controls.
  task automatic do_exec(input int st, input logic b_eq, input logic b_ne, input logic jj,
                         input logic jr, input logic z, input logic [31:0] tgt);
    for (int i = 0; i < st; i++) begin
      stall = 1'b1;
      {beq, bne, j_c, jr_c, zero} = 5'($urandom);
      jr_target = $urandom;
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", pc, m_pc);
      chk("stall_instr", instr, m_instr);
    end
    stall = 1'b0;
    beq = b_eq; bne = b_ne; j_c = jj; jr_c = jr; zero = z; jr_target = tgt;
    if (jr && (tgt[1:0] != 2'b00)) m_mis = 1'b1;
    m_pc = ref_next(m_pc, m_instr, b_eq, b_ne, jj, jr, z, tgt);
    @(negedge clk);
    {beq, bne, j_c, jr_c, zero} = '0;
    jr_target = '0;
    chk("next_addr", imem_addr, m_pc);
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_nvalid", {31'd0, instr_valid}, 32'd0);
    chk("misalign", {31'd0, misalign_err}, {31'd0, m_mis});
    chk("fetch_err", {31'd0, fetch_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] tgt;
    int r;
    m_pc = RESET_PC; m_instr = '0; m_mis = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_ferr", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Sequential fetch, ready in request cycle: 2 cycles per instruction
    for (int k = 0; k < 3; k++) begin
      chk("seq_addr", imem_addr, 32'(k * 4));
      do_fetch(0, $urandom & 32'h03FF_FFFF);
      do_exec(0, 0, 0, 0, 0, 0, 0);
    end

    // Branch at 0x10, imm=-2: taken -> 0x0C, not taken -> 0x14
    do_fetch(0, 32'h0000_0000);
    do_exec(0, 0, 0, 0, 1, 0, 32'h10);
    do_fetch(0, 32'h1000_FFFE);
    do_exec(0, 1, 0, 0, 0, 1, 0);
    chk("beq_taken", imem_addr, 32'h0000_000C);
    do_fetch(0, 32'h0000_0000);
    do_exec(0, 0, 0, 0, 1, 0, 32'h10);
    do_fetch(0, 32'h1000_FFFE);
    do_exec(0, 1, 0, 0, 0, 0, 0);
    chk("beq_ntaken", imem_addr, 32'h0000_0014);

    // j from 0x1000_0040
    do_fetch(0, 32'h0);
    do_exec(0, 0, 0, 0, 1, 0, 32'h1000_0040);
    do_fetch(0, 32'h0800_0100);
    do_exec(0, 0, 0, 1, 0, 0, 0);
    chk("j_target", imem_addr, 32'h1000_0400);

    // jr has priority over j; misaligned target sets the sticky flag
    do_fetch(0, 32'h0800_0100);
    do_exec(0, 0, 0, 1, 1, 0, 32'h203);
    chk("jr_target", imem_addr, 32'h0000_0200);
    chk("jr_misalign", {31'd0, misalign_err}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      do_fetch(0, $urandom);
      do_exec(0, 0, 0, 0, 0, 0, 0);
    end
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Delayed ready and stalled execute
    do_fetch(3, $urandom);
    do_exec(2, 0, 0, 0, 0, 0, 0);

    // Wrap at the top of the address space
    do_fetch(0, $urandom);
    do_exec(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC);
    do_fetch(0, 32'h0);
    do_exec(0, 0, 0, 0, 0, 0, 0);
    chk("wrap", imem_addr, 32'h0000_0000);

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      w = $urandom;
      do_fetch($urandom_range(0, 3), w);
      r = $urandom_range(0, 9);
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      do_exec($urandom_range(0, 2), r == 1 || r == 3, r == 2 || r == 3, r == 4 || r == 6,
              r == 5 || r == 6, 1'($urandom), tgt);
    end

    // Reset between edges while a request is pending
    do_fetch(0, $urandom);
    do_exec(0, 0, 0, 0, 1, 0, 32'h0000_1237);
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pc", pc, RESET_PC);
    chk("arst_instr", instr, 32'd0);
    chk("arst_mis", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RESET_PC; m_mis = 1'b0;
    @(negedge clk);
    do_fetch(1, $urandom);
    do_exec(1, 0, 0, 0, 0, 0, 0);

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: ready never returned
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk("to_req", {31'd0, imem_req}, 32'd1);
      chk("to_nerr", {31'd0, fetch_err}, 32'd0);
      @(negedge clk);
    end
    chk("to_drop", {31'd0, imem_req}, 32'd0);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    @(negedge clk);
    chk("to_rereq", {31'd0, imem_req}, 32'd1);
    chk("to_addr", imem_addr, RESET_PC);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
